mm_stream_driver: RTL
=====================

Name: mm_stream_driver

Overview:
- Initiator/transmitter for the matrix-multiply (MM) engine's streaming input port.
- Holds two 8-bit matrices in a local element buffer and streams them row-major into MM using the in_data/col_end/row_end protocol, gated by MM's busy.
- Collects MM's out_data/valid/is_legal/change_row responses and re-emits them as a checked result stream.
- Sits between a host/config controller and MM.

Parameters:
DIM_W, 4, width of each matrix dimension field (dims 1..15)
MEM_DEPTH, 512, element buffer depth (covers 2*15*15 = 450)
ADDR_W, 9, element buffer address width
TIMEOUT, 4096, max idle cycles in COLLECT with no mm_valid before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ld_en  in  1  write element buffer (honoured only in IDLE)
ld_addr  in  ADDR_W  buffer address; matrix 1 at 0.., matrix 2 immediately after
ld_data  in  8  element value
start  in  1  one-cycle pulse; begin a transaction (honoured only in IDLE)
m1_rows, m1_cols, m2_rows, m2_cols  in  DIM_W each  matrix shapes, sampled on start
mm_busy  in  1  MM busy; a beat transfers only on edges where it is 0
mm_valid  in  1  MM result valid
mm_is_legal  in  1  MM legality flag
mm_out_data  in  20  MM result, signed
mm_change_row  in  1  MM end-of-result-row flag
in_data  out  8  element to MM
col_end  out  1  last element of current matrix row
row_end  out  1  last element of current matrix
res_valid  out  1  captured result strobe
res_data  out  20  captured signed result
res_row_last  out  1  captured result is last in its row
done  out  1  one-cycle pulse at end of transaction
illegal  out  1  MM reported shape mismatch (held until next start)
cfg_err  out  1  any sampled dimension was 0 (held until next start)
timeout  out  1  COLLECT abort (held until next start)
err_cnt  out  8  change_row / is_legal mismatches, saturating at 255; cleared on start

Behaviour:
- Reset: state IDLE. All outputs 0, including in_data, flags, err_cnt and sticky status. Reset mid-transaction aborts with no done pulse; buffer contents are not cleared.
- States: IDLE, SEND1, SEND2, COLLECT, FIN.
- IDLE:
  - ld_en writes the buffer.
  - start latches the shapes and clears err_cnt, illegal, cfg_err and timeout.
  - Any dim = 0: set cfg_err, go to FIN.
  - Otherwise go to SEND1 with the element pointer at 0.
- Sending:
  - Outputs are registered and present the current element every cycle in SEND1/SEND2.
  - A beat completes on a rising edge with mm_busy = 0; the pointer and row/column counters then advance.
  - While mm_busy = 1 the outputs hold.
- SEND1 flags for element index k of M1 (m1_rows*m1_cols elements, buffer addr 0..):
  - col_end = 1 when k mod m1_cols = m1_cols-1.
  - row_end = 1 only on the last element.
  - After the last beat go to SEND2.
- SEND2: same rules for M2 (m2_rows*m2_cols elements at addr m1_rows*m1_cols..). After its last beat, in_data/col_end/row_end drop to 0 and the block goes to COLLECT.
- COLLECT, illegal shape (m1_cols != m2_rows):
  - The first mm_valid completes the transaction.
  - If mm_is_legal = 1, err_cnt increments; illegal is set regardless.
  - No res_valid is produced. Go to FIN.
- COLLECT, legal shape:
  - Expect m1_rows*m2_cols results. Each mm_valid cycle counts as one result.
  - Capture into res_data/res_row_last and pulse res_valid the next cycle (1-cycle latency).
  - Expected change_row = (result column == m2_cols-1); a mismatch increments err_cnt. mm_is_legal = 0 also increments err_cnt.
  - After the last result go to FIN.
- Timeout: an idle counter resets on every mm_valid. Reaching TIMEOUT sets timeout and goes to FIN.
- FIN: pulse done for one cycle, then return to IDLE.
- Ignored inputs: start outside IDLE; ld_en outside IDLE; mm_valid outside COLLECT.
- Arithmetic: element counts up to 225 (8 bits); pointer is ADDR_W bits; no wrap within the legal dim range.

Test Plan:
- M1 2x3 = [1..6], M2 3x2 = [7..12], MM never busy -> 12 consecutive beats. col_end at beats 3, 6, 8, 10, 12; row_end at beats 6 and 12. 4 results 58, 64, 139, 154 with res_row_last = 0,1,0,1; err_cnt = 0; done pulses once.
- Same case with mm_busy high for 3 cycles at beat 4 -> element 4 is held for 3 cycles and delivered exactly once; total beats still 12.
- M1 2x3, M2 2x2 -> after 10 beats, first mm_valid with is_legal = 0 -> illegal = 1, no res_valid, err_cnt = 0, done.
- 1x1 by 1x1 = [255] x [255] -> both beats carry col_end = row_end = 1; result 65025.
- Legal 2x2 case with mm_change_row forced 0 -> err_cnt = 2; m1_rows = 0 -> cfg_err, done within 2 cycles.
- rst asserted during SEND2 -> all outputs 0 next cycle; a new start replays correctly with the buffer intact. No mm_valid for TIMEOUT cycles -> timeout = 1, done.

Source files
------------

// File: rtl/mm_stream_driver.sv
// mm_stream_driver: buffers two 8-bit matrices and streams them row-major
// into the MM engine, then collects and checks MM's result stream.
module mm_stream_driver #(
    parameter int DIM_W     = 4,
    parameter int MEM_DEPTH = 512,
    parameter int ADDR_W    = 9,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [7:0]         ld_data,
    input  logic               start,
    input  logic [DIM_W-1:0]   m1_rows,
    input  logic [DIM_W-1:0]   m1_cols,
    input  logic [DIM_W-1:0]   m2_rows,
    input  logic [DIM_W-1:0]   m2_cols,
    input  logic               mm_busy,
    input  logic               mm_valid,
    input  logic               mm_is_legal,
    input  logic signed [19:0] mm_out_data,
    input  logic               mm_change_row,
    output logic [7:0]         in_data,
    output logic               col_end,
    output logic               row_end,
    output logic               res_valid,
    output logic signed [19:0] res_data,
    output logic               res_row_last,
    output logic               done,
    output logic               illegal,
    output logic               cfg_err,
    output logic               timeout,
    output logic [7:0]         err_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEND1, SEND2, COLLECT, FIN} state_t;

    state_t             state, state_n;
    logic [7:0]         mem [MEM_DEPTH];
    logic [DIM_W-1:0]   r1, c1, r2, c2;
    logic [ADDR_W-1:0]  ptr, ptr_nxt;
    logic [7:0]         elem_idx, elem_nxt;
    logic [DIM_W-1:0]   col_idx, col_nxt;
    logic [7:0]         res_idx;
    logic [DIM_W-1:0]   res_col;
    logic [TW-1:0]      idle_cnt;
    logic [7:0]         n1, n2, nres, cur_n, rd_data;
    logic [DIM_W-1:0]   cur_c;
    logic               sending, beat, last_elem, col_wrap;
    logic               legal_shape, last_res, exp_cr, to_hit, zero_dim;
    logic [1:0]         err_inc;
    logic [8:0]         err_sum;
    logic [7:0]         err_nxt;

    assign n1          = 8'(r1) * 8'(c1);
    assign n2          = 8'(r2) * 8'(c2);
    assign nres        = 8'(r1) * 8'(c2);
    assign legal_shape = (c1 == r2);
    assign exp_cr      = (res_col == c2 - DIM_W'(1));
    assign last_res    = (res_idx == nres - 8'd1);
    assign to_hit      = (idle_cnt == TW'(TIMEOUT - 1));
    assign zero_dim    = (m1_rows == '0) || (m1_cols == '0) ||
                         (m2_rows == '0) || (m2_cols == '0);
    assign ptr_nxt     = ptr + ADDR_W'(1);
    assign rd_data     = mem[ptr_nxt];
    assign err_sum     = {1'b0, err_cnt} + {7'd0, err_inc};
    assign err_nxt     = err_sum[8] ? 8'hFF : err_sum[7:0];

    // Element buffer; host writes only while idle, never cleared by reset
    always_ff @(posedge clk) begin
        if (state == IDLE && ld_en)
            mem[ld_addr] <= ld_data;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = zero_dim ? FIN : SEND1;
            SEND1:   if (beat && last_elem) state_n = SEND2;
            SEND2:   if (beat && last_elem) state_n = COLLECT;
            COLLECT: begin
                if (mm_valid) begin
                    if (!legal_shape || last_res) state_n = FIN;
                end else if (to_hit) begin
                    state_n = FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control strobes: beat qualification, stream position, error increment
    always_comb begin
        sending   = (state == SEND1) || (state == SEND2);
        beat      = sending && !mm_busy;
        cur_c     = (state == SEND1) ? c1 : c2;
        cur_n     = (state == SEND1) ? n1 : n2;
        last_elem = (elem_idx == cur_n - 8'd1);
        col_wrap  = (col_idx == cur_c - DIM_W'(1));
        col_nxt   = col_wrap ? '0 : col_idx + DIM_W'(1);
        elem_nxt  = elem_idx + 8'd1;
        err_inc   = 2'd0;
        if (state == COLLECT && mm_valid) begin
            if (!legal_shape)
                err_inc = {1'b0, mm_is_legal};
            else
                err_inc = {1'b0, mm_change_row != exp_cr} +
                          {1'b0, !mm_is_legal};
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r1 <= '0; c1 <= '0; r2 <= '0; c2 <= '0;
            ptr <= '0; elem_idx <= '0; col_idx <= '0;
            res_idx <= '0; res_col <= '0; idle_cnt <= '0;
            in_data <= '0; col_end <= 1'b0; row_end <= 1'b0;
            res_valid <= 1'b0; res_data <= '0; res_row_last <= 1'b0;
            done <= 1'b0; illegal <= 1'b0; cfg_err <= 1'b0;
            timeout <= 1'b0; err_cnt <= '0;
        end else begin
            done      <= (state_n == FIN);
            res_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        r1 <= m1_rows; c1 <= m1_cols;
                        r2 <= m2_rows; c2 <= m2_cols;
                        err_cnt  <= '0;
                        illegal  <= 1'b0;
                        timeout  <= 1'b0;
                        cfg_err  <= zero_dim;
                        ptr      <= '0;
                        elem_idx <= '0;
                        col_idx  <= '0;
                        if (!zero_dim) begin
                            in_data <= mem[0];
                            col_end <= (m1_cols == DIM_W'(1));
                            row_end <= (m1_rows == DIM_W'(1)) &&
                                       (m1_cols == DIM_W'(1));
                        end
                    end
                end
                SEND1, SEND2: begin
                    if (beat) begin
                        ptr <= ptr_nxt;
                        if (last_elem) begin
                            elem_idx <= '0;
                            col_idx  <= '0;
                            if (state == SEND1) begin
                                in_data <= rd_data;
                                col_end <= (c2 == DIM_W'(1));
                                row_end <= (n2 == 8'd1);
                            end else begin
                                in_data  <= '0;
                                col_end  <= 1'b0;
                                row_end  <= 1'b0;
                                idle_cnt <= '0;
                                res_idx  <= '0;
                                res_col  <= '0;
                            end
                        end else begin
                            elem_idx <= elem_nxt;
                            col_idx  <= col_nxt;
                            in_data  <= rd_data;
                            col_end  <= (col_nxt == cur_c - DIM_W'(1));
                            row_end  <= (elem_nxt == cur_n - 8'd1);
                        end
                    end
                end
                COLLECT: begin
                    if (mm_valid) begin
                        idle_cnt <= '0;
                        err_cnt  <= err_nxt;
                        if (!legal_shape) begin
                            illegal <= 1'b1;
                        end else begin
                            res_valid    <= 1'b1;
                            res_data     <= mm_out_data;
                            res_row_last <= mm_change_row;
                            res_idx      <= res_idx + 8'd1;
                            res_col      <= exp_cr ? '0 : res_col + DIM_W'(1);
                        end
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                        if (to_hit) timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
